// File: rtl/fifo_rd_stream.sv
// Converts a synchronous FIFO's registered, one-cycle-latency read port into
// a valid/ready stream. A two-entry head/skid buffer plus an in-flight flag
// keeps full throughput without ever over-reading the FIFO.
//
// Handshake: a word moves to the consumer on every rising edge where
// o_valid && i_ready. While o_valid is high and i_ready is low, o_valid and
// o_data hold their values. o_valid and o_data depend only on registers.
module fifo_rd_stream #(
  parameter int P_DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_fifo_empty,
  input  logic [P_DATA_W-1:0] i_fifo_data,
  output logic                o_fifo_rd_en,
  output logic                o_valid,
  output logic [P_DATA_W-1:0] o_data,
  input  logic                i_ready,
  output logic [1:0]          o_count
);

  // Two entries cover the read latency: one word held for the consumer,
  // one word landing from the FIFO.
  localparam int unsigned BUF_DEPTH = 2;

  logic [1:0]          count;
  logic                inflight;
  logic [P_DATA_W-1:0] head;
  logic [P_DATA_W-1:0] skid;

  logic                pop;
  logic                capture;
  logic [2:0]          occ_after_pop;

  // Issue a read only when the word it returns is guaranteed a free slot,
  // counting the word already in flight and the slot freed by a pop.
  always_comb begin
    pop           = (count != 2'd0) && i_ready;
    capture       = inflight;
    occ_after_pop = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    o_fifo_rd_en  = !i_fifo_empty && rst_n && (occ_after_pop < 3'(BUF_DEPTH));
  end

  // Buffer, occupancy and in-flight flag. A capture lands in the first slot
  // left free after any same-cycle pop, so FIFO order is preserved.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count    <= 2'd0;
      inflight <= 1'b0;
      head     <= '0;
      skid     <= '0;
    end else begin
      inflight <= o_fifo_rd_en;
      count    <= count + {1'b0, capture} - {1'b0, pop};
      if (pop && capture) begin
        if (count == 2'd1) begin
          head <= i_fifo_data;
        end else begin
          head <= skid;
          skid <= i_fifo_data;
        end
      end else if (pop) begin
        head <= skid;
      end else if (capture) begin
        if (count == 2'd0) begin
          head <= i_fifo_data;
        end else begin
          skid <= i_fifo_data;
        end
      end
    end
  end

  assign o_valid = (count != 2'd0);
  assign o_data  = head;
  assign o_count = count;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream paired with a behavioural synchronous FIFO
// (8 bits wide, 8 deep, registered read data). Stimulus pushes every
// written byte onto exp_q; a monitor pops and compares on each transfer.
module tb_fifo_rd_stream;

  localparam int W = 8;
  localparam int FIFO_DEPTH = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         fifo_empty;
  logic [W-1:0] fifo_data;
  logic         rd_en;
  logic         valid;
  logic [W-1:0] data;
  logic         ready = 1'b0;
  logic [1:0]   count;

  int tests = 0;
  int failed = 0;

  logic [W-1:0] exp_q[$];

  fifo_rd_stream #(.P_DATA_W(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_fifo_empty (fifo_empty),
    .i_fifo_data  (fifo_data),
    .o_fifo_rd_en (rd_en),
    .o_valid      (valid),
    .o_data       (data),
    .i_ready      (ready),
    .o_count      (count)
  );

  // ---------------- clock / reset / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- behavioural upstream FIFO ----------------
  logic         wr_en = 1'b0;
  logic [W-1:0] wr_data = '0;
  logic [W-1:0] f_mem [FIFO_DEPTH];
  int           f_wp = 0;
  int           f_rp = 0;
  int           f_cnt = 0;
  logic [W-1:0] f_rdata = '0;

  assign fifo_empty = (f_cnt == 0);
  assign fifo_data  = f_rdata;

  always @(posedge clk) begin
    if (!rst_n) begin
      f_wp    <= 0;
      f_rp    <= 0;
      f_cnt   <= 0;
      f_rdata <= '0;
    end else begin
      int rd, wr;
      rd = (rd_en && f_cnt != 0) ? 1 : 0;
      wr = (wr_en && (f_cnt < FIFO_DEPTH || rd == 1)) ? 1 : 0;
      if (rd == 1) begin
        f_rdata <= f_mem[f_rp];
        f_rp    <= (f_rp + 1) % FIFO_DEPTH;
      end
      if (wr == 1) begin
        f_mem[f_wp] <= wr_data;
        f_wp        <= (f_wp + 1) % FIFO_DEPTH;
      end
      f_cnt <= f_cnt + wr - rd;
    end
  end

  // ---------------- reference model of buffer occupancy ----------------
  // A word requested in one cycle arrives the next and is buffered after
  // that; each transfer removes one word.
  int   cnt_m = 0;
  int   inflight_m = 0;
  logic rst_q = 1'b0;

  always @(posedge clk) begin
    rst_q <= rst_n;
    if (!rst_n) begin
      cnt_m      <= 0;
      inflight_m <= 0;
      exp_q.delete();
    end else begin
      cnt_m      <= cnt_m + inflight_m - (((cnt_m != 0) && ready) ? 1 : 0);
      inflight_m <= rd_en ? 1 : 0;
    end
  end

  // ---------------- checker ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    int   pop_m;
    logic exp_rd;
    pop_m  = ((cnt_m != 0) && ready) ? 1 : 0;
    exp_rd = rst_n && (f_cnt != 0) && ((cnt_m + inflight_m - pop_m) < 2);
    check("rd_en", 32'(rd_en), 32'(exp_rd));
    check("rd_en_while_empty", 32'(rd_en && fifo_empty), 32'd0);
    check("occupancy_le_2", 32'((cnt_m + inflight_m) <= 2), 32'd1);
    check("count", 32'(count), 32'(cnt_m));
    check("valid", 32'(valid), 32'(cnt_m != 0));
    if (!rst_q) begin
      check("reset_valid", 32'(valid), 32'd0);
      check("reset_data", 32'(data), 32'd0);
      check("reset_count", 32'(count), 32'd0);
    end
    if (rst_n && rst_q && valid && ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_transfer", 32'(data), 32'hFFFF_FFFF);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("stream_data", 32'(data), 32'(e));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [W-1:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    exp_q.push_back(d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_valid(input int max_cycles);
    int n;
    n = 0;
    while (!valid && n < max_cycles) begin
      tick();
      n++;
    end
    check("wait_valid", 32'(valid), 32'd1);
  endtask

  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      tick();
      n++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Power-up reset.
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Reset with data held in the FIFO and the buffer.
    ready = 1'b0;
    push_word(8'h11);
    push_word(8'h22);
    push_word(8'h33);
    repeat (3) tick();
    check("prereset_count", 32'(count), 32'd2);
    rst_n = 1'b0;
    check("reset_rd_en_now", 32'(rd_en), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_rd_en", 32'(rd_en), 32'd0);
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_data", 32'(data), 32'd0);
      check("rst_count", 32'(count), 32'd0);
    end
    rst_n = 1'b1;
    tick();

    // First-word latency.
    ready = 1'b1;
    push_word(8'hA5);
    check("lat_rd_en", 32'(rd_en), 32'd1);
    check("lat_valid_n1", 32'(valid), 32'd0);
    tick();
    check("lat_valid_n2", 32'(valid), 32'd0);
    tick();
    check("lat_valid_n3", 32'(valid), 32'd1);
    check("lat_data", 32'(data), 32'hA5);
    tick();
    check("lat_single", 32'(valid), 32'd0);
    repeat (2) tick();

    // Back-to-back streaming without gaps.
    fork
      begin
        for (int i = 1; i <= 8; i++) push_word(W'(i));
      end
      begin
        wait_valid(10);
        for (int i = 1; i <= 8; i++) begin
          check("stream_gapless_valid", 32'(valid), 32'd1);
          check("stream_order", 32'(data), 32'(i));
          tick();
        end
        check("stream_end", 32'(valid), 32'd0);
      end
    join
    drain(20);

    // Backpressure.
    ready = 1'b0;
    for (int i = 1; i <= 8; i++) push_word(W'(i));
    for (int i = 0; i < 10; i++) begin
      check("bp_count", 32'(count), 32'd2);
      check("bp_rd_en", 32'(rd_en), 32'd0);
      check("bp_valid", 32'(valid), 32'd1);
      check("bp_data", 32'(data), 32'h01);
      tick();
    end
    ready = 1'b1;
    drain(40);

    // Random data with random ready.
    begin
      int written;
      int guard;
      written = 0;
      guard   = 0;
      while (written < 200 && guard < 5000) begin
        ready = 1'($urandom_range(0, 1));
        if (f_cnt < FIFO_DEPTH && $urandom_range(0, 3) != 0) begin
          logic [W-1:0] d;
          d       = W'($urandom_range(0, 255));
          wr_en   = 1'b1;
          wr_data = d;
          exp_q.push_back(d);
          written++;
        end else begin
          wr_en = 1'b0;
        end
        tick();
        guard++;
      end
      wr_en = 1'b0;
      check("random_written", 32'(written), 32'd200);
      ready = 1'b1;
      drain(100);
    end

    // Reset mid-operation with a word in flight.
    ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(W'(8'h50 + i));
    repeat (3) tick();
    check("mid_full", 32'(count), 32'd2);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("mid_count_before_rst", 32'(count), 32'd1);
    rst_n = 1'b0;
    tick();
    check("mid_valid_after_rst", 32'(valid), 32'd0);
    check("mid_count_after_rst", 32'(count), 32'd0);
    rst_n = 1'b1;
    tick();
    ready = 1'b1;
    push_word(8'h3C);
    wait_valid(10);
    check("mid_first_word", 32'(data), 32'h3C);
    drain(20);
    repeat (3) tick();
    check("final_idle_valid", 32'(valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
